clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set controller for an HH:MM:SS clock.
//
// In RUN the block turns tick_1hz into cascaded count-enable pulses for the
// seconds, minutes and hours counters. The mode key cycles
// RUN -> SET_HH -> SET_MM -> RUN. The inc key steps the field being set.
// Leaving SET_MM with the mode key clears the seconds. If no key is pressed
// for TIMEOUT_TICKS seconds, the block drops back to RUN without clearing
// the seconds.
//
// Optional feature: define CLOCK_SET_AUTO_REPEAT_EN to auto-repeat a held
// inc key. The first repeat comes REPEAT_DLY clks after the press, then one
// every REPEAT_PER clks.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   tick_1hz            one-clk pulse per second
//   key_mode, key_inc   debounced asynchronous key levels, high = pressed
//   sec_max, min_max    seconds / minutes counters at 59
//   sec_en/min_en/hr_en registered one-cycle count enables
//   sec_clr             registered one-cycle seconds clear
//   mode                00 RUN, 01 SET_HH, 10 SET_MM
//   blink_hr/blink_min  blank request for the field being set
module clock_set_ctrl #(
    parameter int          TIMEOUT_TICKS = 10,
    parameter logic [23:0] REPEAT_DLY    = 24'd1000000,
    parameter logic [23:0] REPEAT_PER    = 24'd250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink_hr,
    output logic       blink_min
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SET_HH = 2'b01,
        SET_MM = 2'b10
    } mode_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);

    mode_t      state;
    logic [7:0] idle;
    logic       phase;

    // [0],[1] synchroniser, [2] edge reference. Reset to 1 so that a key
    // already held when reset is released does not look like a press.
    logic [2:0] mode_sync, inc_sync;
    logic       mode_ev, inc_key_ev, inc_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_sync <= 3'b111;
            inc_sync  <= 3'b111;
        end else begin
            mode_sync <= {mode_sync[1:0], key_mode};
            inc_sync  <= {inc_sync[1:0], key_inc};
        end
    end

    assign mode_ev    = mode_sync[1] & ~mode_sync[2];
    assign inc_key_ev = inc_sync[1] & ~inc_sync[2];

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    logic [23:0] rpt_cnt;
    logic        rpt_on, rpt_first, rpt_ev;

    // rpt_cnt counts clks since the last accepted inc (real or repeated).
    assign rpt_ev = rpt_on && inc_sync[1] &&
                    (rpt_cnt == (rpt_first ? REPEAT_DLY : REPEAT_PER) - 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_on    <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (mode_ev || !inc_sync[1] || state == RUN) begin
            // Release, a mode change (which also swallows a coincident
            // inc) or RUN all stop the repeat.
            rpt_on  <= 1'b0;
            rpt_cnt <= '0;
        end else if (inc_key_ev || rpt_ev) begin
            rpt_on    <= 1'b1;
            rpt_first <= inc_key_ev;
            rpt_cnt   <= '0;
        end else if (rpt_on) begin
            rpt_cnt <= rpt_cnt + 24'd1;
        end
    end

    assign inc_ev = inc_key_ev | rpt_ev;
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DLY, REPEAT_PER};
    assign inc_ev     = inc_key_ev;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            idle    <= '0;
            phase   <= 1'b0;
            sec_en  <= 1'b0;
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            sec_clr <= 1'b0;
        end else begin
            sec_en  <= 1'b0;
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            sec_clr <= 1'b0;

            if (tick_1hz)
                phase <= ~phase;

            // A tick seen in RUN always counts, even if the mode key fires
            // in the same cycle. Ticks in SET modes are dropped.
            if (state == RUN && tick_1hz) begin
                sec_en <= 1'b1;
                min_en <= sec_max;
                hr_en  <= sec_max & min_max;
            end

            if (mode_ev) begin
                idle <= '0;
                case (state)
                    RUN:     state <= SET_HH;
                    SET_HH:  state <= SET_MM;
                    default: begin
                        state   <= RUN;
                        sec_clr <= 1'b1;
                    end
                endcase
            end else if (state == RUN) begin
                idle <= '0;
            end else if (inc_ev) begin
                idle <= '0;
                if (state == SET_HH)
                    hr_en <= 1'b1;
                else
                    min_en <= 1'b1;
            end else if (tick_1hz) begin
                if (idle == TIMEOUT_LAST) begin
                    state <= RUN;
                    idle  <= '0;
                end else begin
                    idle <= idle + 8'd1;
                end
            end
        end
    end

    assign mode      = state;
    assign blink_hr  = (state == SET_HH) & phase;
    assign blink_min = (state == SET_MM) & phase;

endmodule
